pending_encoder_4_2: RTL and testbench
======================================

# pending_encoder_4_2

Sequential counterpart of the 2-to-4 decoder: collects one-hot or multi-hot request pulses on `Input` and emits them one at a time as binary indices on `Output` through a valid/ready handshake. Requests are held in a sticky pending register until issued. Selection is by fixed priority (highest index wins) or, with the macro below, by round-robin. It sits wherever a set of request lines must be serialised into a single index stream, for example to drive a downstream `decoder_2_4`.

## Interface
- `N`, 4, number of request lines; legal values 2, 4, 8.
- `W`, derived localparam, clog2(N), index width; 2 at default.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `enable`  input  1  when 0, `Input` is ignored; queued work keeps draining.
- `Input`  input  N  request pulses; bit i set for one cycle requests index i.
- `ready`  input  1  downstream accepts `Output` when `valid` is also high.
- `Output`  output  W  issued index, registered.
- `valid`  output  1  `Output` holds an issued index, registered.
- `pending`  output  N  requests not yet issued, registered.
- `dropped`  output  1  one-cycle pulse: a request merged into an already-pending bit.

## Operation
- Reset values: `pending`=0, `Output`=0, `valid`=0, `dropped`=0, round-robin pointer=N-1.
- States: EMPTY (`valid`=0) and FULL (`valid`=1).
- `load` = EMPTY or (FULL and `ready`).
- On load with `pending`≠0:
  - select index s from `pending`;
  - `Output`<=s; `valid`<=1 (FULL);
  - clear bit s in `pending`.
- On load with `pending`=0: `valid`<=0 (EMPTY); `Output` keeps its last value.
- FULL and not `ready`: `Output` and `valid` hold, with no other change.
- Request capture: `req` = `Input` & {N{`enable`}}; `pending_next` = (`pending` & ~clear) | `req`.
  - Set wins over clear: a request on bit s in the same cycle s is issued leaves bit s set, so s is issued again later.
- `dropped`<=1 when any bit of `req` is set on a bit that is already pending and not being cleared that cycle. The duplicate is lost; only one issue occurs.
- A request for the index currently held in `Output` (FULL, not yet accepted) is a new request and is queued normally.
- Fixed priority: s is the highest set index of `pending`.
- Reset asserted in any state forces reset values on the next edge and discards all pending and held work.

## Timing
- `Input` sampled at edge k appears in `pending` after edge k.
- That index can appear on `Output`/`valid` after edge k+1, a 2-edge latency when the output stage is empty.
- Throughput: one index per cycle while `ready`=1.
- `valid`, once high, stays high with `Output` stable until a cycle with `ready`=1.
- `dropped` is registered and aligned with the `pending` update it describes.

## Configuration
- `PENDING_ENCODER_RR_EN` defined:
  - round-robin selection; search starts at pointer+1 modulo N and picks the first set bit upward with wrap;
  - the pointer updates to s on each issue;
  - after reset, index 0 has top priority.
- Undefined: fixed priority with highest index first; no pointer register.

## Structure
- Shared package `encoder_pkg` holds:
  - state encodings EMPTY/FULL;
  - function `onehot_clr(idx, N)` returning an N-bit mask;
  - function for clog2 width.
- One sub-module, `prio_select`, is natural: combinational, inputs `pending` and a start index, outputs `found` and index s.
  - Fixed mode ties the start index to N-1 and searches downward.
  - RR mode passes pointer+1 and searches upward with wrap.

## Test plan
- Reset, `Input`=0000 for 5 cycles -> `valid`=0, `Output`=0, `pending`=0000, `dropped`=0 throughout.
- `Input`=1010 for one cycle, `ready`=1 -> fixed mode gives `Output`=3 then 1, then `valid`=0; RR mode gives 1 then 3. `pending` reads 1010, then 0010, then 0000.
- `ready`=0, `Input`=0100 then 0001 -> `Output`=2 held with `valid`=1 and `pending`=0001. Raise `ready` -> next `Output`=0, then `valid`=0.
- `ready`=0 with bit 1 already pending, `Input`=0010 again -> `dropped`=1 for exactly one cycle; index 1 is issued only once.
- `Input`=1000 on the cycle index 3 is loaded -> index 3 issued twice in consecutive accepts.
- `enable`=0 with `Input`=1111 -> `pending` unchanged and nothing issued. With `valid`=1 and `pending`=0110, assert `reset` one cycle -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/pending_encoder_4_2_pkg.sv
// Shared definitions for the pending encoder: output-stage state encoding,
// index-width helper and the one-hot clear mask used when an index is issued.
package encoder_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic int clog2w(input int n);
    int r;
    r = 32'sd0;
    for (int i = 32'sd0; i < 32'sd8; i++) begin
      if ((32'sd1 << i) < n) r = i + 32'sd1;
    end
    return r;
  endfunction

  // Sized for the largest legal N; callers truncate to their own width.
  function automatic logic [7:0] onehot_clr(input int idx, input int n);
    logic [7:0] m;
    m = 8'd0;
    if (idx < n) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pending_encoder_4_2_if.sv
// Request/issue bundle of the pending encoder. The slave modport is the
// encoder side; the master modport is the requester/consumer side.
interface pending_encoder_4_2_if #(
  parameter int N = 4
);
  localparam int W = encoder_pkg::clog2w(N);

  logic         enable;
  logic [N-1:0] Input;
  logic         ready;
  logic [W-1:0] Output;
  logic         valid;
  logic [N-1:0] pending;
  logic         dropped;

  modport slave (
    input  enable, Input, ready,
    output Output, valid, pending, dropped
  );

  modport master (
    output enable, Input, ready,
    input  Output, valid, pending, dropped
  );
endinterface

// File: rtl/pending_encoder_4_2_prio_select.sv
// Picks one set bit of pending_i. Default build: highest index first.
// With PENDING_ENCODER_RR_EN: first set bit at or above start_i, wrapping.
module prio_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] pending_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  // Scan from the far end so the candidate closest to start_i is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = {W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
`ifdef PENDING_ENCODER_RR_EN
      if (pending_i[(int'(start_i) + k) % N]) begin
        found_o = 1'b1;
        idx_o   = W'((int'(start_i) + k) % N);
      end else begin
        found_o = found_o;
      end
`else
      if (pending_i[(int'(start_i) - k + N) % N]) begin
        found_o = 1'b1;
        idx_o   = W'((int'(start_i) - k + N) % N);
      end else begin
        found_o = found_o;
      end
`endif
    end
  end

endmodule

// File: rtl/pending_encoder_4_2.sv
// Serialises sticky request bits into a valid/ready stream of binary indices.
// Optional round-robin selection: define PENDING_ENCODER_RR_EN.
module pending_encoder_4_2
  import encoder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pending_encoder_4_2_if.slave  bus
);

  localparam int W = clog2w(N);

  state_e       state_q;
  logic [N-1:0] pending_q;
  logic [N-1:0] pending_d;
  logic [W-1:0] out_q;
  logic         dropped_q;
  logic         dropped_d;

  logic         load_s;
  logic         found_s;
  logic         issue_s;
  logic [W-1:0] sel_s;
  logic [W-1:0] start_s;
  logic [N-1:0] req_s;
  logic [N-1:0] clr_s;

`ifdef PENDING_ENCODER_RR_EN
  logic [W-1:0] ptr_q;
  assign start_s = W'((int'(ptr_q) + 32'sd1) % N);
`else
  assign start_s = W'(N - 1);
`endif

  prio_select #(.N(N), .W(W)) u_sel (
    .pending_i (pending_q),
    .start_i   (start_s),
    .found_o   (found_s),
    .idx_o     (sel_s)
  );

  // Load decision, clear mask and next pending set; a fresh request beats the clear.
  always_comb begin
    case (state_q)
      EMPTY:   load_s = 1'b1;
      FULL:    load_s = bus.ready;
      default: load_s = 1'b1;
    endcase
    issue_s   = load_s && found_s;
    req_s     = bus.Input & {N{bus.enable}};
    if (issue_s) begin
      clr_s = N'(onehot_clr(int'(sel_s), N));
    end else begin
      clr_s = {N{1'b0}};
    end
    pending_d = (pending_q & ~clr_s) | req_s;
    dropped_d = |(req_s & pending_q & ~clr_s);
  end

  // Output-stage FSM plus the pending/dropped registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      out_q     <= {W{1'b0}};
      pending_q <= {N{1'b0}};
      dropped_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      if (load_s) begin
        if (found_s) begin
          state_q <= FULL;
          out_q   <= sel_s;
        end else begin
          state_q <= EMPTY;
        end
      end
    end
  end

`ifdef PENDING_ENCODER_RR_EN
  // Round-robin pointer remembers the last issued index.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= W'(N - 1);
    end else if (issue_s) begin
      ptr_q <= sel_s;
    end
  end
`endif

  assign bus.Output  = out_q;
  assign bus.valid   = (state_q == FULL);
  assign bus.pending = pending_q;
  assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_pending_encoder_4_2.sv
// Self-checking bench for pending_encoder_4_2: directed scenarios plus a
// randomized run against a set-based reference model.
module tb_pending_encoder_4_2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pending_encoder_4_2_if #(.N(4)) bus ();

  pending_encoder_4_2 #(.N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a set of outstanding indices and a one-entry output slot.
  bit m_pend[4];
  int m_out;
  bit m_valid;
  bit m_drop;
  int m_ptr;

  function automatic int pick();
    int s;
    s = -1;
`ifdef PENDING_ENCODER_RR_EN
    for (int k = 1; k <= 4; k++) begin
      if (s < 0 && m_pend[(m_ptr + k) % 4]) s = (m_ptr + k) % 4;
    end
`else
    for (int i = 0; i < 4; i++) if (m_pend[i]) s = i;
`endif
    return s;
  endfunction

  function automatic logic [3:0] exp_pend();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic tick();
    int  s;
    bit  issue;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
      m_out = 0; m_valid = 1'b0; m_drop = 1'b0; m_ptr = 3;
    end else begin
      issue = 1'b0;
      s = pick();
      if (!m_valid || bus.ready) begin
        if (s >= 0) begin
          issue = 1'b1; m_out = s; m_valid = 1'b1; m_ptr = s; m_pend[s] = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_drop = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (bus.enable && bus.Input[i]) begin
          if (m_pend[i]) m_drop = 1'b1;
          m_pend[i] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.enable = 1'b1; bus.Input = 4'b0000; bus.ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc %0d got %b want 0", c, bus.valid); end
      n_checks++; if (bus.Output !== 2'd0) begin n_fail++; $display("FAIL reset_output cyc %0d got %0d want 0", c, bus.Output); end
      n_checks++; if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending cyc %0d got %b want 0000", c, bus.pending); end
      n_checks++; if (bus.dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped cyc %0d got %b want 0", c, bus.dropped); end
    end
  endtask

  task automatic test_order();
    logic [1:0] first, second;
`ifdef PENDING_ENCODER_RR_EN
    first = 2'd1; second = 2'd3;
`else
    first = 2'd3; second = 2'd1;
`endif
    do_reset();
    bus.Input = 4'b1010; tick(); bus.Input = 4'b0000;
    n_checks++; if (bus.pending !== 4'b1010 || bus.valid !== 1'b0) begin n_fail++; $display("FAIL order_capture got pend %b valid %b want 1010/0", bus.pending, bus.valid); end
    tick();
    n_checks++; if (bus.Output !== first || bus.valid !== 1'b1 || bus.pending !== (4'b1010 & ~(4'b0001 << first))) begin n_fail++; $display("FAIL order_first got %0d/%b/%b want %0d/1", bus.Output, bus.valid, bus.pending, first); end
    tick();
    n_checks++; if (bus.Output !== second || bus.valid !== 1'b1 || bus.pending !== 4'b0000) begin n_fail++; $display("FAIL order_second got %0d/%b/%b want %0d/1/0000", bus.Output, bus.valid, bus.pending, second); end
    tick();
    n_checks++; if (bus.valid !== 1'b0 || bus.Output !== second) begin n_fail++; $display("FAIL order_drain got valid %b out %0d want 0/%0d", bus.valid, bus.Output, second); end
  endtask

  task automatic test_hold();
    do_reset();
    bus.ready = 1'b0;
    bus.Input = 4'b0100; tick();
    bus.Input = 4'b0001; tick();
    bus.Input = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (bus.Output !== 2'd2 || bus.valid !== 1'b1 || bus.pending !== 4'b0001) begin n_fail++; $display("FAIL hold cyc %0d got %0d/%b/%b want 2/1/0001", c, bus.Output, bus.valid, bus.pending); end
      tick();
    end
    bus.ready = 1'b1; tick();
    n_checks++; if (bus.Output !== 2'd0 || bus.valid !== 1'b1 || bus.pending !== 4'b0000) begin n_fail++; $display("FAIL hold_release got %0d/%b/%b want 0/1/0000", bus.Output, bus.valid, bus.pending); end
    tick();
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL hold_drain got valid %b want 0", bus.valid); end
  endtask

  task automatic test_dropped();
    int ones;
    do_reset();
    bus.ready = 1'b0;
    bus.Input = 4'b0100; tick(); bus.Input = 4'b0000; tick();
    bus.Input = 4'b0010; tick();
    n_checks++; if (bus.dropped !== 1'b0 || bus.pending !== 4'b0010) begin n_fail++; $display("FAIL drop_first got %b/%b want 0/0010", bus.dropped, bus.pending); end
    tick(); bus.Input = 4'b0000;
    n_checks++; if (bus.dropped !== 1'b1 || bus.pending !== 4'b0010) begin n_fail++; $display("FAIL drop_dup got %b/%b want 1/0010", bus.dropped, bus.pending); end
    tick();
    n_checks++; if (bus.dropped !== 1'b0) begin n_fail++; $display("FAIL drop_pulse got %b want 0", bus.dropped); end
    bus.ready = 1'b1;
    ones = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.valid && bus.Output == 2'd1) ones++;
    end
    n_checks++; if (ones !== 1) begin n_fail++; $display("FAIL drop_single_issue got %0d issues want 1", ones); end
  endtask

  task automatic test_reissue();
    do_reset();
    bus.Input = 4'b1000; tick(); tick(); bus.Input = 4'b0000;
    n_checks++; if (bus.Output !== 2'd3 || bus.valid !== 1'b1 || bus.pending !== 4'b1000 || bus.dropped !== 1'b0) begin n_fail++; $display("FAIL reissue_a got %0d/%b/%b/%b want 3/1/1000/0", bus.Output, bus.valid, bus.pending, bus.dropped); end
    tick();
    n_checks++; if (bus.Output !== 2'd3 || bus.valid !== 1'b1 || bus.pending !== 4'b0000) begin n_fail++; $display("FAIL reissue_b got %0d/%b/%b want 3/1/0000", bus.Output, bus.valid, bus.pending); end
    tick();
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reissue_drain got valid %b want 0", bus.valid); end
  endtask

  task automatic test_enable_reset();
    do_reset();
    bus.enable = 1'b0; bus.Input = 4'b1111;
    for (int c = 0; c < 3; c++) tick();
    n_checks++; if (bus.pending !== 4'b0000 || bus.valid !== 1'b0) begin n_fail++; $display("FAIL enable_off got %b/%b want 0000/0", bus.pending, bus.valid); end
    bus.enable = 1'b1; bus.ready = 1'b0; bus.Input = 4'b1110; tick();
    bus.Input = 4'b0000; tick();
    n_checks++; if (bus.valid !== 1'b1 || bus.pending !== exp_pend()) begin n_fail++; $display("FAIL pre_reset got %b/%b want 1/%b", bus.valid, bus.pending, exp_pend()); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (bus.valid !== 1'b0 || bus.Output !== 2'd0 || bus.pending !== 4'b0000 || bus.dropped !== 1'b0) begin n_fail++; $display("FAIL mid_reset got %b/%0d/%b/%b want 0/0/0000/0", bus.valid, bus.Output, bus.pending, bus.dropped); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 49) == 0);
      bus.enable = ($urandom_range(0, 5) != 0);
      bus.ready  = ($urandom_range(0, 2) != 0);
      bus.Input  = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'b0000;
      tick();
      n_checks++; if (bus.valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, bus.valid, m_valid); end
      n_checks++; if (bus.Output !== 2'(m_out)) begin n_fail++; $display("FAIL rnd_output cyc %0d got %0d want %0d", c, bus.Output, m_out); end
      n_checks++; if (bus.pending !== exp_pend()) begin n_fail++; $display("FAIL rnd_pending cyc %0d got %b want %b", c, bus.pending, exp_pend()); end
      n_checks++; if (bus.dropped !== m_drop) begin n_fail++; $display("FAIL rnd_dropped cyc %0d got %b want %b", c, bus.dropped, m_drop); end
    end
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; bus.enable = 1'b0; bus.Input = 4'b0000; bus.ready = 1'b0;
    test_reset();
    test_order();
    test_hold();
    test_dropped();
    test_reissue();
    test_enable_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
